// File: rtl/alphasoc_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port word RAM with a
// registered read. Each access runs IDLE -> ACCESS -> RESP.
module alphasoc_mem_arbiter #(
  parameter int unsigned WORDS = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        p0_valid,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wstrb,
  output logic        p0_ready,
  output logic [31:0] p0_rdata,
  input  logic        p1_valid,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wstrb,
  output logic        p1_ready,
  output logic [31:0] p1_rdata,
  output logic [3:0]  mem_wen,
  output logic [21:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic        grant, last_grant, oor;
  logic        req, sel, idx_oor;
  logic [21:0] idx;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{p0_addr[31:24], p0_addr[1:0], p1_addr[31:24], p1_addr[1:0]};

  // Arbitration: single requester wins; on a tie the port not served last wins.
  always_comb begin
    req     = p0_valid | p1_valid;
    sel     = (p0_valid && p1_valid) ? ~last_grant : p1_valid;
    idx     = sel ? p1_addr[23:2] : p0_addr[23:2];
    idx_oor = {10'd0, idx} >= WORDS;
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: fixed three-cycle sequence per access.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping and registered RAM-side outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      oor        <= 1'b0;
      mem_wen    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            grant     <= sel;
            oor       <= idx_oor;
            mem_addr  <= idx;
            mem_wdata <= sel ? p1_wdata : p0_wdata;
            mem_wen   <= idx_oor ? 4'b0000 : (sel ? p1_wstrb : p0_wstrb);
          end
        end
        ACCESS:  mem_wen    <= '0;
        RESP:    last_grant <= grant;
        default: ;
      endcase
    end
  end

  // Response outputs: only the granted port sees ready/rdata in RESP.
  always_comb begin
    busy     = (state != IDLE);
    p0_ready = (state == RESP) && !grant;
    p1_ready = (state == RESP) &&  grant;
    p0_rdata = (p0_ready && !oor) ? mem_rdata : 32'h0;
    p1_rdata = (p1_ready && !oor) ? mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_alphasoc_mem_arbiter.sv
// Directed testbench for alphasoc_mem_arbiter with a behavioural
// registered-read RAM attached to the memory side.
module tb_alphasoc_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        p0_valid, p1_valid;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic [3:0]  p0_wstrb, p1_wstrb;
  logic        p0_ready, p1_ready;
  logic [31:0] p0_rdata, p1_rdata;
  logic [3:0]  mem_wen;
  logic [21:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  int passed = 0;
  int total  = 0;

  logic [31:0] ram [256];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  always #5 clk = ~clk;

  alphasoc_mem_arbiter #(.WORDS(256)) dut (
    .clk(clk), .resetn(resetn),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb),
    .p0_ready(p0_ready), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb),
    .p1_ready(p1_ready), .p1_rdata(p1_rdata),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // RAM model: byte-enabled write, registered read; out-of-range reads return garbage.
  always @(posedge clk) begin
    if (pre_en) ram[pre_idx] <= pre_val;
    else if (mem_addr < 22'd256) begin
      for (int b = 0; b < 4; b++)
        if (mem_wen[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= (mem_addr < 22'd256) ? ram[mem_addr[7:0]] : 32'hBAD0BAD0;
  end

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Drives one request in cycle 0 and samples cycles 1..3. When hold is 0 the
  // valid drops right after the grant edge; otherwise addr/wdata are scrambled.
  task automatic run_access(input logic port, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic hold,
                            output logic [3:0] wen1, output logic [21:0] addr1,
                            output logic [31:0] wdata1, output logic rdy1, output logic busy1,
                            output logic own2, output logic other2,
                            output logic [31:0] rdata2, output logic [31:0] other_rdata2,
                            output logic [3:0] wen2, output logic busy3, output logic rdy3);
    if (port == 1'b0) begin
      p0_valid = 1'b1; p0_addr = addr; p0_wdata = wdata; p0_wstrb = wstrb;
    end else begin
      p1_valid = 1'b1; p1_addr = addr; p1_wdata = wdata; p1_wstrb = wstrb;
    end
    @(posedge clk); #1;
    if (port == 1'b0) begin
      p0_valid = hold; p0_addr = ~addr; p0_wdata = ~wdata; p0_wstrb = ~wstrb;
    end else begin
      p1_valid = hold; p1_addr = ~addr; p1_wdata = ~wdata; p1_wstrb = ~wstrb;
    end
    wen1 = mem_wen; addr1 = mem_addr; wdata1 = mem_wdata;
    rdy1 = p0_ready | p1_ready; busy1 = busy;
    @(posedge clk); #1;
    own2   = port ? p1_ready : p0_ready;
    other2 = port ? p0_ready : p1_ready;
    rdata2 = port ? p1_rdata : p0_rdata;
    other_rdata2 = port ? p0_rdata : p1_rdata;
    wen2 = mem_wen;
    p0_valid = 1'b0; p1_valid = 1'b0;
    p0_wstrb = '0; p1_wstrb = '0;
    @(posedge clk); #1;
    busy3 = busy; rdy3 = p0_ready | p1_ready;
  endtask

  logic [3:0]  wen1, wen2;
  logic [21:0] addr1;
  logic [31:0] wdata1, rdata2, ordata2;
  logic        rdy1, busy1, own2, other2, busy3, rdy3;

  task automatic test_reset;
    resetn = 1'b0;
    p0_valid = 0; p1_valid = 0; p0_addr = '0; p1_addr = '0;
    p0_wdata = '0; p1_wdata = '0; p0_wstrb = '0; p1_wstrb = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if ({p0_ready, p1_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {p0_ready, p1_ready}); else passed++;
    total++; if (mem_wen !== 4'h0) $display("FAIL reset_wen: got %h want 0", mem_wen); else passed++;
    total++; if (mem_addr !== 22'h0) $display("FAIL reset_addr: got %h want 0", mem_addr); else passed++;
    total++; if (mem_wdata !== 32'h0) $display("FAIL reset_wdata: got %h want 0", mem_wdata); else passed++;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read;
    preload(8'd5, 32'hDEADBEEF);
    run_access(1'b0, 32'h14, 32'h12345678, 4'h0, 1'b1, wen1, addr1, wdata1, rdy1, busy1,
               own2, other2, rdata2, ordata2, wen2, busy3, rdy3);
    total++; if (addr1 !== 22'd5) $display("FAIL read_addr_c1: got %h want 5", addr1); else passed++;
    total++; if (wen1 !== 4'h0) $display("FAIL read_wen_c1: got %h want 0", wen1); else passed++;
    total++; if (rdy1 !== 1'b0) $display("FAIL read_ready_c1: got %b want 0", rdy1); else passed++;
    total++; if (busy1 !== 1'b1) $display("FAIL read_busy_c1: got %b want 1", busy1); else passed++;
    total++; if (own2 !== 1'b1) $display("FAIL read_p0_ready_c2: got %b want 1", own2); else passed++;
    total++; if (other2 !== 1'b0) $display("FAIL read_p1_ready_c2: got %b want 0", other2); else passed++;
    total++; if (rdata2 !== 32'hDEADBEEF) $display("FAIL read_rdata: got %h want DEADBEEF", rdata2); else passed++;
    total++; if (ordata2 !== 32'h0) $display("FAIL read_other_rdata: got %h want 0", ordata2); else passed++;
    total++; if (rdy3 !== 1'b0) $display("FAIL read_ready_c3: got %b want 0", rdy3); else passed++;
  endtask

  task automatic test_byte_write;
    preload(8'd3, 32'h11223344);
    run_access(1'b1, 32'hC, 32'hAABBCCDD, 4'b0101, 1'b1, wen1, addr1, wdata1, rdy1, busy1,
               own2, other2, rdata2, ordata2, wen2, busy3, rdy3);
    total++; if (wen1 !== 4'b0101) $display("FAIL bytewr_wen_c1: got %b want 0101", wen1); else passed++;
    total++; if (addr1 !== 22'd3) $display("FAIL bytewr_addr_c1: got %h want 3", addr1); else passed++;
    total++; if (wdata1 !== 32'hAABBCCDD) $display("FAIL bytewr_wdata_c1: got %h want AABBCCDD", wdata1); else passed++;
    total++; if (own2 !== 1'b1) $display("FAIL bytewr_p1_ready_c2: got %b want 1", own2); else passed++;
    total++; if (other2 !== 1'b0) $display("FAIL bytewr_p0_ready_c2: got %b want 0", other2); else passed++;
    total++; if (wen2 !== 4'h0) $display("FAIL bytewr_wen_c2: got %b want 0000", wen2); else passed++;
    run_access(1'b0, 32'hC, 32'h0, 4'h0, 1'b1, wen1, addr1, wdata1, rdy1, busy1,
               own2, other2, rdata2, ordata2, wen2, busy3, rdy3);
    total++; if (rdata2 !== 32'h11BB33DD) $display("FAIL bytewr_readback: got %h want 11BB33DD", rdata2); else passed++;
  endtask

  task automatic test_contention;
    logic [1:0] exp;
    preload(8'd10, 32'h0A0A0A0A);
    preload(8'd20, 32'h14141414);
    resetn = 1'b0;
    p0_valid = 1'b1; p0_addr = 32'h28; p0_wstrb = '0;
    p1_valid = 1'b1; p1_addr = 32'h50; p1_wstrb = '0;
    #2;
    @(negedge clk); resetn = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      exp = {(c == 5 || c == 11), (c == 2 || c == 8)};
      total++;
      if ({p1_ready, p0_ready} !== exp)
        $display("FAIL contend_ready_c%0d: got p1,p0=%b want %b", c, {p1_ready, p0_ready}, exp);
      else passed++;
      if (c == 2) begin
        total++; if (p0_rdata !== 32'h0A0A0A0A) $display("FAIL contend_p0_rdata: got %h want 0A0A0A0A", p0_rdata); else passed++;
      end
      if (c == 5) begin
        total++; if (p1_rdata !== 32'h14141414) $display("FAIL contend_p1_rdata: got %h want 14141414", p1_rdata); else passed++;
      end
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range;
    preload(8'd0, 32'hCAFEF00D);
    run_access(1'b1, 32'h400, 32'h99999999, 4'hF, 1'b1, wen1, addr1, wdata1, rdy1, busy1,
               own2, other2, rdata2, ordata2, wen2, busy3, rdy3);
    total++; if (wen1 !== 4'h0) $display("FAIL oor_wen_c1: got %b want 0000", wen1); else passed++;
    total++; if (own2 !== 1'b1) $display("FAIL oor_p1_ready_c2: got %b want 1", own2); else passed++;
    total++; if (ram[0] !== 32'hCAFEF00D) $display("FAIL oor_word0_intact: got %h want CAFEF00D", ram[0]); else passed++;
    run_access(1'b0, 32'h400, 32'h0, 4'h0, 1'b1, wen1, addr1, wdata1, rdy1, busy1,
               own2, other2, rdata2, ordata2, wen2, busy3, rdy3);
    total++; if (own2 !== 1'b1) $display("FAIL oor_p0_ready_c2: got %b want 1", own2); else passed++;
    total++; if (rdata2 !== 32'h0) $display("FAIL oor_p0_rdata: got %h want 0", rdata2); else passed++;
  endtask

  task automatic test_reset_midop;
    preload(8'd7, 32'h77777777);
    p1_valid = 1'b1; p1_addr = 32'h1C; p1_wdata = 32'h0; p1_wstrb = 4'hF;
    @(posedge clk); #1;
    p1_valid = 1'b0; p1_wstrb = '0;
    total++; if (mem_wen !== 4'hF) $display("FAIL midrst_wen_before: got %b want 1111", mem_wen); else passed++;
    resetn = 1'b0;
    #1;
    total++; if (mem_wen !== 4'h0) $display("FAIL midrst_wen_async: got %b want 0000", mem_wen); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL midrst_busy_async: got %b want 0", busy); else passed++;
    total++; if ({p0_ready, p1_ready} !== 2'b00) $display("FAIL midrst_ready_async: got %b want 00", {p0_ready, p1_ready}); else passed++;
    @(posedge clk); @(negedge clk);
    total++; if (ram[7] !== 32'h77777777) $display("FAIL midrst_word_intact: got %h want 77777777", ram[7]); else passed++;
    resetn = 1'b1;
    p0_valid = 1'b1; p0_addr = 32'h28; p0_wstrb = '0;
    p1_valid = 1'b1; p1_addr = 32'h50; p1_wstrb = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if ({p1_ready, p0_ready} !== 2'b01) $display("FAIL midrst_p0_first: got p1,p0=%b want 01", {p1_ready, p0_ready}); else passed++;
    total++; if (p0_rdata !== 32'h0A0A0A0A) $display("FAIL midrst_p0_rdata: got %h want 0A0A0A0A", p0_rdata); else passed++;
    p0_valid = 1'b0; p1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_valid_dropped;
    run_access(1'b0, 32'h14, 32'h0, 4'h0, 1'b0, wen1, addr1, wdata1, rdy1, busy1,
               own2, other2, rdata2, ordata2, wen2, busy3, rdy3);
    total++; if (busy1 !== 1'b1) $display("FAIL drop_busy_c1: got %b want 1", busy1); else passed++;
    total++; if (own2 !== 1'b1) $display("FAIL drop_p0_ready_c2: got %b want 1", own2); else passed++;
    total++; if (rdata2 !== 32'hDEADBEEF) $display("FAIL drop_rdata: got %h want DEADBEEF", rdata2); else passed++;
    total++; if (busy3 !== 1'b0) $display("FAIL drop_busy_c3: got %b want 0", busy3); else passed++;
    total++; if (rdy3 !== 1'b0) $display("FAIL drop_ready_c3: got %b want 0", rdy3); else passed++;
  endtask

  task automatic test_back_to_back;
    run_access(1'b1, 32'h28, 32'h0, 4'h0, 1'b1, wen1, addr1, wdata1, rdy1, busy1,
               own2, other2, rdata2, ordata2, wen2, busy3, rdy3);
    total++; if (rdata2 !== 32'h0A0A0A0A) $display("FAIL b2b_first_rdata: got %h want 0A0A0A0A", rdata2); else passed++;
    run_access(1'b1, 32'h50, 32'h0, 4'h0, 1'b1, wen1, addr1, wdata1, rdy1, busy1,
               own2, other2, rdata2, ordata2, wen2, busy3, rdy3);
    total++; if (own2 !== 1'b1) $display("FAIL b2b_second_ready: got %b want 1", own2); else passed++;
    total++; if (rdata2 !== 32'h14141414) $display("FAIL b2b_second_rdata: got %h want 14141414", rdata2); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_byte_write();
    test_contention();
    test_out_of_range();
    test_reset_midop();
    test_valid_dropped();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
